// File: rtl/rx_drop_fifo_pkg.sv
// Shared definitions for the rx MAC drop-on-error frame FIFO: beat geometry,
// storage entry layout and the write-side state encoding.
package rx_drop_fifo_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int DATA_NBYTES = 4;
    localparam int ENTRY_WIDTH = DATA_WIDTH + DATA_NBYTES + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_FLUSH,
        ST_DISCARD
    } wr_state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  data;
        logic [DATA_NBYTES-1:0] keep;
        logic                   last;
    } entry_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rx_drop_fifo_sdp_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, so it maps
// onto distributed RAM or a block RAM with an output register downstream.
module sdp_ram #(
    parameter int WIDTH  = 37,
    parameter int ADDR_W = 9
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/rx_drop_fifo.sv
// Receive frame FIFO that stores frames speculatively and forwards only those
// that end with good FCS and fit entirely; bad or overflowed frames are rolled back.
module rx_drop_fifo
    import rx_drop_fifo_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic [DATA_WIDTH-1:0]  s00_axis_tdata,
    input  logic [DATA_NBYTES-1:0] s00_axis_tkeep,
    input  logic                   s00_axis_tvalid,
    input  logic                   s00_axis_tlast,
    input  logic                   s00_axis_tuser,
    output logic [DATA_WIDTH-1:0]  m00_axis_tdata,
    output logic [DATA_NBYTES-1:0] m00_axis_tkeep,
    output logic                   m00_axis_tvalid,
    output logic                   m00_axis_tlast,
    input  logic                   m00_axis_tready,
    output logic [15:0]            o_good_frames,
    output logic [15:0]            o_dropped_frames,
    output logic                   o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    wr_state_e     state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d, rd_ptr_q, rd_ptr_d;
    entry_t        hold_q, hold_d, m_entry_q, m_entry_d;
    logic          hold_valid_q, hold_valid_d;
    logic          tuser_q, tuser_d;
    logic          ovf_flag_q, ovf_flag_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   good_q, good_d, drop_q, drop_d;
    logic          m_valid_q, m_valid_d;

    logic                   mem_we;
    logic [ENTRY_WIDTH-1:0] rd_data;
    logic                   full, empty, ovf_now;
    logic [PW-1:0]          wr_post;

    // Full uses the registered rd_ptr, so a same-cycle read frees space one cycle later.
    assign full  = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
    assign empty = (rd_ptr_q == wr_commit_q);

    sdp_ram #(
        .WIDTH (ENTRY_WIDTH),
        .ADDR_W(AW)
    ) u_ram (
        .i_clk    (i_clk),
        .i_wr_en  (mem_we),
        .i_wr_addr(wr_ptr_q[AW-1:0]),
        .i_wr_data(hold_q),
        .i_rd_addr(rd_ptr_q[AW-1:0]),
        .o_rd_data(rd_data)
    );

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        wr_commit_d  = wr_commit_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        tuser_d      = tuser_q;
        ovf_flag_d   = ovf_flag_q;
        overflow_d   = 1'b0;
        good_d       = good_q;
        drop_d       = drop_q;
        mem_we       = 1'b0;
        ovf_now      = 1'b0;
        wr_post      = wr_ptr_q;
        case (state_q)
            ST_IDLE, ST_RECV: begin
                if (s00_axis_tvalid) begin
                    if (s00_axis_tlast && s00_axis_tkeep == '0) begin
                        // Empty closing beat: it only marks the held beat as the frame end.
                        hold_d.last = 1'b1;
                    end else begin
                        if (hold_valid_q) begin
                            if (full) begin
                                ovf_now = 1'b1;
                            end else begin
                                mem_we   = 1'b1;
                                wr_ptr_d = wr_ptr_q + 1'b1;
                            end
                        end
                        if (!ovf_now) begin
                            hold_d       = '{data: s00_axis_tdata, keep: s00_axis_tkeep,
                                             last: s00_axis_tlast};
                            hold_valid_d = 1'b1;
                        end
                    end
                    if (ovf_now) begin
                        ovf_flag_d   = 1'b1;
                        overflow_d   = 1'b1;
                        hold_valid_d = 1'b0;
                    end
                    if (s00_axis_tlast) begin
                        tuser_d = s00_axis_tuser;
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ovf_now ? ST_DISCARD : ST_RECV;
                    end
                end
            end
            ST_DISCARD: begin
                if (s00_axis_tvalid && s00_axis_tlast) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                ovf_now = ovf_flag_q;
                if (hold_valid_q && !ovf_flag_q) begin
                    if (full) begin
                        ovf_now    = 1'b1;
                        overflow_d = 1'b1;
                    end else begin
                        mem_we  = 1'b1;
                        wr_post = wr_ptr_q + 1'b1;
                    end
                end
                if (tuser_q && !ovf_now && wr_post != wr_commit_q) begin
                    wr_ptr_d    = wr_post;
                    wr_commit_d = wr_post;
                    good_d      = sat_inc(good_q);
                end else begin
                    wr_ptr_d = wr_commit_q;
                    drop_d   = sat_inc(drop_q);
                end
                hold_valid_d = 1'b0;
                ovf_flag_d   = 1'b0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        m_entry_d = m_entry_q;
        m_valid_d = m_valid_q;
        if ((!m_valid_q || m00_axis_tready) && !empty) begin
            m_entry_d = entry_t'(rd_data);
            m_valid_d = 1'b1;
            rd_ptr_d  = rd_ptr_q + 1'b1;
        end else if (m00_axis_tready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            wr_commit_q  <= '0;
            rd_ptr_q     <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            tuser_q      <= 1'b0;
            ovf_flag_q   <= 1'b0;
            overflow_q   <= 1'b0;
            good_q       <= '0;
            drop_q       <= '0;
            m_entry_q    <= '0;
            m_valid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            wr_commit_q  <= wr_commit_d;
            rd_ptr_q     <= rd_ptr_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            tuser_q      <= tuser_d;
            ovf_flag_q   <= ovf_flag_d;
            overflow_q   <= overflow_d;
            good_q       <= good_d;
            drop_q       <= drop_d;
            m_entry_q    <= m_entry_d;
            m_valid_q    <= m_valid_d;
        end
    end

    assign m00_axis_tdata   = m_entry_q.data;
    assign m00_axis_tkeep   = m_entry_q.keep;
    assign m00_axis_tlast   = m_entry_q.last;
    assign m00_axis_tvalid  = m_valid_q;
    assign o_good_frames    = good_q;
    assign o_dropped_frames = drop_q;
    assign o_overflow       = overflow_q;

endmodule

// File: tb/tb_rx_drop_fifo.sv
// Self-checking bench for rx_drop_fifo: directed frame scenarios plus a long
// randomized run scored against a frame-level reference model.
module tb_rx_drop_fifo;

    localparam int DEPTH = 16;
    localparam int LIMIT = 4000;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tkeep = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tuser = 1'b0;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b0;
    logic [15:0] good_frames, dropped_frames;
    logic        overflow;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    last_accept_cyc = 0;
    int    exp_good = 0;
    int    exp_drop = 0;
    int    ovf_pulses = 0;
    int    stab_viol = 0;
    bit    ready_mode = 1'b0;
    logic  ready_level = 1'b0;
    word_t exp_q[$];
    word_t got_q[$];
    bit    prev_stall = 1'b0;
    word_t prev_word;

    rx_drop_fifo #(.DEPTH(DEPTH)) dut (
        .i_clk           (i_clk),
        .i_reset_n       (i_reset_n),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tkeep  (s_tkeep),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tuser  (s_tuser),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tkeep  (m_tkeep),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tlast  (m_tlast),
        .m00_axis_tready (m_tready),
        .o_good_frames   (good_frames),
        .o_dropped_frames(dropped_frames),
        .o_overflow      (overflow)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc++;

    always @(posedge i_clk) begin
        #1;
        m_tready = ready_mode ? 1'($urandom_range(0, 1)) : ready_level;
    end

    // Output collector: records accepted words, stall stability and overflow pulses.
    always @(negedge i_clk) begin
        if (!i_reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (m_tvalid !== 1'b1 || {m_tdata, m_tkeep, m_tlast} !== prev_word))
                stab_viol++;
            if (m_tvalid && m_tready) got_q.push_back('{m_tdata, m_tkeep, m_tlast});
            prev_stall = m_tvalid && !m_tready;
            prev_word  = '{m_tdata, m_tkeep, m_tlast};
            if (overflow === 1'b1) ovf_pulses++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            s_tkeep  = '0;
        end
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                              input logic u);
        @(posedge i_clk);
        #1;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tuser  = u;
    endtask

    // Reference: a frame is forwarded iff tuser=1, it has at least one data
    // byte and it was not overflowed; its bytes are packed little-endian.
    task automatic send_frame(input int nbytes, input bit zero_end, input bit tuser,
                              input bit expect_ovf);
        word_t words[$];
        int    nwords;
        bit    kept;
        logic [31:0] d;
        logic [3:0]  k;
        nwords = (nbytes + 3) / 4;
        for (int w = 0; w < nwords; w++) begin
            d = '0;
            k = '0;
            for (int b = 0; b < 4; b++) begin
                if (w * 4 + b < nbytes) begin
                    d[8*b +: 8] = 8'($urandom);
                    k[b]        = 1'b1;
                end
            end
            words.push_back('{d, k, (w == nwords - 1)});
        end
        for (int w = 0; w < nwords; w++) begin
            drive_beat(words[w].data, words[w].keep, words[w].last && !zero_end, tuser);
            if (words[w].last && !zero_end) last_accept_cyc = cyc + 1;
        end
        if (zero_end || nwords == 0) begin
            drive_beat(32'($urandom), 4'b0000, 1'b1, tuser);
            last_accept_cyc = cyc + 1;
        end
        idle(1);
        kept = tuser && nwords > 0 && !expect_ovf;
        if (kept) begin
            foreach (words[w]) exp_q.push_back(words[w]);
            exp_good++;
        end else begin
            exp_drop++;
        end
        $display("frame bytes=%0d words=%0d zero_end=%0b tuser=%0b -> %s",
                 nbytes, nwords, zero_end, tuser, kept ? "commit" : "drop");
    endtask

    task automatic test_reset();
        repeat (3) @(posedge i_clk);
        #1;
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset tvalid: got %b want 0", m_tvalid); end
        checks++; if (m_tdata !== 32'h0) begin errors++; $display("FAIL reset tdata: got %h want 0", m_tdata); end
        checks++; if (m_tkeep !== 4'h0) begin errors++; $display("FAIL reset tkeep: got %h want 0", m_tkeep); end
        checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset tlast: got %b want 0", m_tlast); end
        checks++; if (good_frames !== 16'd0) begin errors++; $display("FAIL reset good: got %0d want 0", good_frames); end
        checks++; if (dropped_frames !== 16'd0) begin errors++; $display("FAIL reset dropped: got %0d want 0", dropped_frames); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b want 0", overflow); end
        i_reset_n = 1'b1;
        idle(2);
    endtask

    task automatic test_good_frame();
        int t;
        ready_level = 1'b1;
        idle(2);
        send_frame(64, 1'b0, 1'b1, 1'b0);
        t = 0;
        while (m_tvalid !== 1'b1 && t < 100) begin @(negedge i_clk); t++; end
        checks++;
        if (cyc - last_accept_cyc != 2) begin
            errors++;
            $display("FAIL good_frame latency: got %0d cycles want 2", cyc - last_accept_cyc);
        end
        t = 0;
        while (got_q.size() < exp_q.size() && t < LIMIT) begin @(negedge i_clk); t++; end
        repeat (4) @(negedge i_clk);
        checks++; if (got_q.size() != 16) begin errors++; $display("FAIL good_frame words: got %0d want 16", got_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL good_frame word %0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (good_frames !== 16'(exp_good)) begin errors++; $display("FAIL good_frame good: got %0d want %0d", good_frames, exp_good); end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_zero_keep_end();
        int t;
        send_frame(61, 1'b1, 1'b1, 1'b0);
        t = 0;
        while (got_q.size() < exp_q.size() && t < LIMIT) begin @(negedge i_clk); t++; end
        repeat (4) @(negedge i_clk);
        checks++; if (got_q.size() != 16) begin errors++; $display("FAIL zero_keep words: got %0d want 16", got_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL zero_keep word %0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() == 16) begin
            checks++;
            if (got_q[15].keep !== 4'b0001 || got_q[15].last !== 1'b1) begin
                errors++; $display("FAIL zero_keep tail: got keep=%b last=%b want 0001/1", got_q[15].keep, got_q[15].last);
            end
        end
        checks++; if (good_frames !== 16'(exp_good)) begin errors++; $display("FAIL zero_keep good: got %0d want %0d", good_frames, exp_good); end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_bad_between();
        int t;
        send_frame(40, 1'b0, 1'b1, 1'b0);
        send_frame(32, 1'b0, 1'b0, 1'b0);
        send_frame(22, 1'b1, 1'b1, 1'b0);
        t = 0;
        while (got_q.size() < exp_q.size() && t < LIMIT) begin @(negedge i_clk); t++; end
        repeat (4) @(negedge i_clk);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bad_between words: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bad_between word %0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (good_frames !== 16'(exp_good)) begin errors++; $display("FAIL bad_between good: got %0d want %0d", good_frames, exp_good); end
        checks++; if (dropped_frames !== 16'(exp_drop)) begin errors++; $display("FAIL bad_between dropped: got %0d want %0d", dropped_frames, exp_drop); end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_overflow();
        int t;
        ready_level = 1'b0;
        ovf_pulses  = 0;
        idle(2);
        send_frame(80, 1'b0, 1'b1, 1'b1);
        repeat (5) @(negedge i_clk);
        checks++; if (ovf_pulses != 1) begin errors++; $display("FAIL overflow pulses: got %0d want 1", ovf_pulses); end
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL overflow fifo_empty: got tvalid=%b want 0", m_tvalid); end
        checks++; if (dropped_frames !== 16'(exp_drop)) begin errors++; $display("FAIL overflow dropped: got %0d want %0d", dropped_frames, exp_drop); end
        send_frame(32, 1'b0, 1'b1, 1'b0);
        idle(3);
        ready_level = 1'b1;
        t = 0;
        while (got_q.size() < exp_q.size() && t < LIMIT) begin @(negedge i_clk); t++; end
        repeat (4) @(negedge i_clk);
        checks++; if (got_q.size() != 8) begin errors++; $display("FAIL overflow next_words: got %0d want 8", got_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL overflow next_word %0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (good_frames !== 16'(exp_good)) begin errors++; $display("FAIL overflow good: got %0d want %0d", good_frames, exp_good); end
        checks++; if (ovf_pulses != 1) begin errors++; $display("FAIL overflow pulses_after: got %0d want 1", ovf_pulses); end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_random();
        int t, nbytes, nwords;
        bit zero_end, tuser;
        ready_mode = 1'b1;
        ovf_pulses = 0;
        stab_viol  = 0;
        for (int f = 0; f < 1000; f++) begin
            nbytes   = $urandom_range(0, 64);
            zero_end = (nbytes == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
            tuser    = ($urandom_range(0, 4) != 0);
            nwords   = (nbytes + 3) / 4;
            t = 0;
            while ((exp_q.size() - got_q.size()) + nwords > DEPTH && t < LIMIT) begin
                @(negedge i_clk); t++;
            end
            checks++;
            if (t >= LIMIT) begin errors++; $display("FAIL random space_wait frame %0d: outstanding %0d", f, exp_q.size() - got_q.size()); end
            idle($urandom_range(0, 2));
            send_frame(nbytes, zero_end, tuser, 1'b0);
        end
        t = 0;
        while (got_q.size() < exp_q.size() && t < LIMIT) begin @(negedge i_clk); t++; end
        repeat (8) @(negedge i_clk);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL random words: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL random word %0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (good_frames !== 16'(exp_good)) begin errors++; $display("FAIL random good: got %0d want %0d", good_frames, exp_good); end
        checks++; if (dropped_frames !== 16'(exp_drop)) begin errors++; $display("FAIL random dropped: got %0d want %0d", dropped_frames, exp_drop); end
        checks++; if (stab_viol != 0) begin errors++; $display("FAIL random stall_stability: got %0d violations want 0", stab_viol); end
        checks++; if (ovf_pulses != 0) begin errors++; $display("FAIL random overflow: got %0d pulses want 0", ovf_pulses); end
        ready_mode = 1'b0;
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_mid();
        int t;
        ready_level = 1'b0;
        idle(2);
        send_frame(16, 1'b0, 1'b1, 1'b0);
        for (int b = 0; b < 3; b++) drive_beat(32'($urandom), 4'hF, 1'b0, 1'b1);
        checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL reset_mid pre_tvalid: got %b want 1", m_tvalid); end
        #2;
        i_reset_n = 1'b0;
        s_tvalid  = 1'b0;
        #1;
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_mid tvalid: got %b want 0", m_tvalid); end
        checks++; if ({m_tdata, m_tkeep, m_tlast} !== 37'h0) begin errors++; $display("FAIL reset_mid data: got %h want 0", {m_tdata, m_tkeep, m_tlast}); end
        checks++; if (good_frames !== 16'd0 || dropped_frames !== 16'd0) begin
            errors++; $display("FAIL reset_mid counters: got %0d/%0d want 0/0", good_frames, dropped_frames);
        end
        exp_q.delete(); got_q.delete();
        exp_good = 0;
        exp_drop = 0;
        repeat (2) @(posedge i_clk);
        #1;
        i_reset_n   = 1'b1;
        ready_level = 1'b1;
        idle(2);
        send_frame(28, 1'b0, 1'b1, 1'b0);
        t = 0;
        while (got_q.size() < exp_q.size() && t < LIMIT) begin @(negedge i_clk); t++; end
        repeat (6) @(negedge i_clk);
        checks++; if (got_q.size() != 7) begin errors++; $display("FAIL reset_mid words: got %0d want 7", got_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL reset_mid word %0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (good_frames !== 16'd1 || dropped_frames !== 16'd0) begin
            errors++; $display("FAIL reset_mid post_counters: got %0d/%0d want 1/0", good_frames, dropped_frames);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_zero_keep_end();
        test_bad_between();
        test_overflow();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
